// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one register-to-register instruction, drives the external
// registered ALU for one cycle, then writes its result and flags back (IDLE/ISSUE/WB).
`default_nettype none

module alu_sequencer #(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [1:0]              instr_op,
  input  logic [$clog2(NREG)-1:0] instr_rd,
  input  logic [$clog2(NREG)-1:0] instr_rs,
  input  logic [$clog2(NREG)-1:0] instr_rt,
  input  logic                    ld_valid,
  input  logic [$clog2(NREG)-1:0] ld_addr,
  input  logic [W-1:0]            ld_data,
  output logic [W-1:0]            alu_X,
  output logic [W-1:0]            alu_Y,
  output logic [1:0]              alu_funSel,
  input  logic [W-1:0]            alu_Z,
  input  logic [3:0]              alu_flags,
  output logic                    done,
  output logic [3:0]              status_flags,
  input  logic [$clog2(NREG)-1:0] dbg_rsel,
  output logic [W-1:0]            dbg_rdata
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   rs_q;
  logic [AW-1:0]   rt_q;
  logic [W-1:0]    regs [NREG];

  // Operands are read during ISSUE itself so a write-back on the accepting edge is already visible.
  assign alu_X      = (state == ISSUE) ? regs[rs_q] : '0;
  assign alu_Y      = (state == ISSUE) ? regs[rt_q] : '0;
  assign alu_funSel = (state == ISSUE) ? op_q       : 2'b00;
  assign dbg_rdata  = regs[dbg_rsel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      instr_ready  <= 1'b1;
      done         <= 1'b0;
      status_flags <= 4'b0000;
      op_q         <= 2'b00;
      rd_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // The write-back below is assigned later, so it overrides a colliding load.
      if (ld_valid) begin
        regs[ld_addr] <= ld_data;
      end
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q        <= instr_op;
            rd_q        <= instr_rd;
            rs_q        <= instr_rs;
            rt_q        <= instr_rt;
            state       <= ISSUE;
            instr_ready <= 1'b0;
          end
        end
        ISSUE: begin
          state       <= WB;
          done        <= 1'b1;
          instr_ready <= 1'b1;
        end
        WB: begin
          regs[rd_q]   <= alu_Z;
          status_flags <= alu_flags;
          done         <= 1'b0;
          if (instr_valid) begin
            op_q        <= instr_op;
            rd_q        <= instr_rd;
            rs_q        <= instr_rs;
            rt_q        <= instr_rt;
            state       <= ISSUE;
            instr_ready <= 1'b0;
          end else begin
            state       <= IDLE;
            instr_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          done        <= 1'b0;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed plan steps plus randomized instructions,
// with a behavioural ALU attached and an architectural register-file model.
`default_nettype none

module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_op;
  logic [2:0]  instr_rd, instr_rs, instr_rt;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_X, alu_Y;
  logic [1:0]  alu_funSel;
  logic [15:0] alu_Z;
  logic [3:0]  alu_flags;
  logic        done;
  logic [3:0]  status_flags;
  logic [2:0]  dbg_rsel;
  logic [15:0] dbg_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] M [8];
  logic [3:0]  exp_flags;
  bit          pv;
  logic [2:0]  prd;
  logic [15:0] pres;
  logic [3:0]  pfl;

  alu_sequencer #(.W(16), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_X(alu_X), .alu_Y(alu_Y), .alu_funSel(alu_funSel),
    .alu_Z(alu_Z), .alu_flags(alu_flags),
    .done(done), .status_flags(status_flags),
    .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // Registered 16-bit ALU the sequencer talks to (no reset, as in the real part).
  always @(posedge clk) begin : alu_model
    logic [16:0] t;
    logic        v;
    case (alu_funSel)
      2'b00: begin
        t = {1'b0, alu_X} + {1'b0, alu_Y};
        v = (alu_X[15] == alu_Y[15]) && (t[15] != alu_X[15]);
      end
      2'b01: begin
        t = {1'b0, ~alu_X} + {1'b0, alu_Y} + 17'd1;
        v = (~alu_X[15] == alu_Y[15]) && (t[15] != alu_Y[15]);
      end
      2'b10: begin
        t = {1'b0, alu_X};
        v = 1'b0;
      end
      default: begin
        t = {1'b0, 16'd0 - alu_X};
        v = 1'b0;
      end
    endcase
    alu_Z     <= t[15:0];
    alu_flags <= {t[15], v, (alu_funSel[1] ? 1'b0 : t[16]), (t[15:0] == 16'd0)};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result: plain integer arithmetic on the register values.
  function automatic void ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic [3:0] f);
    int sa = $signed(a);
    int sb = $signed(b);
    int sr = 0;
    bit c = 1'b0;
    bit v = 1'b0;
    case (op)
      2'b00: begin
        r  = a + b;
        c  = (int'(a) + int'(b)) > 65535;
        sr = sa + sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      2'b01: begin
        r  = b - a;
        c  = (b >= a);
        sr = sb - sa;
        v  = (sr > 32767) || (sr < -32768);
      end
      2'b10: r = a;
      default: r = 16'd0 - a;
    endcase
    f = {r[15], v, c, (r == 16'd0)};
  endfunction

  task automatic commit_pending();
    if (pv) begin
      M[prd]    = pres;
      exp_flags = pfl;
      pv        = 1'b0;
    end
  endtask

  // Presents an instruction in a ready cycle (IDLE or WB); returns during its WB cycle.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    @(negedge clk);
    chk("ready_before_accept", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    commit_pending();
    chk("issue_ready", instr_ready, 1'b0);
    chk("issue_done", done, 1'b0);
    chk("issue_X", alu_X, M[rs]);
    chk("issue_Y", alu_Y, M[rt]);
    chk("issue_fun", alu_funSel, op);
    ref_op(op, M[rs], M[rt], pres, pfl);
    prd = rd;
    pv  = 1'b1;
    @(posedge clk); #1;
    chk("wb_done", done, 1'b1);
    chk("wb_ready", instr_ready, 1'b1);
    chk("wb_X_zero", alu_X, 16'd0);
    chk("wb_fun_zero", alu_funSel, 2'b00);
  endtask

  task automatic finish_wb();
    logic [2:0] rd;
    rd = prd;
    @(posedge clk); #1;
    commit_pending();
    chk("idle_done", done, 1'b0);
    chk("status_flags", status_flags, exp_flags);
    dbg_rsel = rd; #1;
    chk("result_reg", dbg_rdata, M[rd]);
  endtask

  task automatic do_load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    M[a] = d;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_rsel = 3'(i); #1;
      chk(tag, dbg_rdata, M[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0; instr_op = 2'b00; instr_rd = 3'd0; instr_rs = 3'd0; instr_rt = 3'd0;
    ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 16'd0; dbg_rsel = 3'd0;
    for (int i = 0; i < 8; i++) M[i] = 16'd0;
    exp_flags = 4'b0000; pv = 1'b0; prd = 3'd0; pres = 16'd0; pfl = 4'b0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", status_flags, 4'b0000);
    chk("rst_X", alu_X, 16'd0);
    check_all_regs("rst_reg");
    @(negedge clk); rst_n = 1'b1;

    // Directed plan
    do_load(3'd1, 16'h0005);
    do_load(3'd2, 16'h0003);
    issue(2'b00, 3'd3, 3'd1, 3'd2); finish_wb();
    chk("add_value", M[3], 16'h0008);
    issue(2'b01, 3'd4, 3'd1, 3'd2); finish_wb();
    chk("sub_flags", status_flags, 4'b1000);
    do_load(3'd5, 16'h7FFF);
    do_load(3'd6, 16'h0001);
    issue(2'b00, 3'd7, 3'd5, 3'd6); finish_wb();
    chk("ovf_flags", status_flags, 4'b1100);
    issue(2'b11, 3'd0, 3'd0, 3'd0); finish_wb();
    chk("neg0_flags", status_flags, 4'b0001);
    issue(2'b10, 3'd6, 3'd1, 3'd0); finish_wb();
    chk("mov_value", dbg_rdata, 16'h0005);

    // Back-to-back dependent pair
    issue(2'b00, 3'd3, 3'd1, 3'd2);
    issue(2'b00, 3'd4, 3'd3, 3'd3);
    finish_wb();
    chk("b2b_value", dbg_rdata, 16'h0010);

    // Load colliding with write-back to the same register
    issue(2'b00, 3'd2, 3'd1, 3'd1);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 3'd2; ld_data = 16'hBEEF;
    finish_wb();
    ld_valid = 1'b0;
    chk("collide_wb_wins", dbg_rdata, 16'h000A);

    // Randomized instructions, some chained, some with a load elsewhere during WB
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_load(3'($urandom_range(0, 7)), 16'($urandom));
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0)
        issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) begin
        logic [2:0]  la;
        logic [15:0] ldv;
        la  = prd + 3'($urandom_range(1, 7));
        ldv = 16'($urandom);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = la; ld_data = ldv;
        M[la] = ldv;
        finish_wb();
        ld_valid = 1'b0;
      end else begin
        finish_wb();
      end
    end
    check_all_regs("rand_reg");

    // Reset during ISSUE discards the in-flight instruction
    do_load(3'd1, 16'h1234);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 2'b00; instr_rd = 3'd5; instr_rs = 3'd1; instr_rt = 3'd1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rst_issue_ready", instr_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_ready", instr_ready, 1'b1);
    chk("rst_mid_flags", status_flags, 4'b0000);
    for (int i = 0; i < 8; i++) M[i] = 16'd0;
    exp_flags = 4'b0000;
    pv = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_after_done", done, 1'b0);
    end
    check_all_regs("rst_after_reg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control stage that sits directly upstream and downstream of the 16-bit registered ALU (add/sub/transfer/negate, 4-bit S/V/C/Z flags). It accepts one register-to-register instruction through a valid/ready handshake and reads both operands from an internal 8×16 register file. It drives the ALU's X/Y/funSel inputs, waits out the ALU's one-cycle registered latency, then writes the ALU result back to the destination register and latches the flags.

## Interface
- W, 16, data width; must match the ALU.
- NREG, 8, register-file depth; register addresses are log2(NREG) = 3 bits.
- Clock and reset (already decided): one clock `clk`; reset `rst_n`, asynchronous, active-low.
- clk  in  1  rising-edge clock, shared with the ALU.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept; transfer occurs when valid&&ready at a rising edge.
- instr_op  in  2  00 ADD, 01 SUB, 10 MOV, 11 NEG.
- instr_rd / instr_rs / instr_rt  in  3 each  destination and source register addresses.
- ld_valid  in  1  external register-load strobe.
- ld_addr  in  3  external register-load address.
- ld_data  in  16  external register-load data.
- alu_X  out  16  ALU X input.
- alu_Y  out  16  ALU Y input.
- alu_funSel  out  2  ALU function select.
- alu_Z  in  16  registered ALU result.
- alu_flags  in  4  registered ALU flags: [0]=Z, [1]=C, [2]=V, [3]=S.
- done  out  1  high for exactly the WB cycle.
- status_flags  out  4  flags of the last completed instruction.
- dbg_rsel  in  3  debug read address.
- dbg_rdata  out  16  combinational R[dbg_rsel].

## Operation
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - instr_ready=1.
  - On accept, latch op/rd/rs/rt and go to ISSUE.
- ISSUE:
  - instr_ready=0.
  - alu_X=R[rs], alu_Y=R[rt], alu_funSel=op, all read combinationally from the register file.
  - Always go to WB.
- WB:
  - done=1 and instr_ready=1.
  - At the closing edge: R[rd]←alu_Z and status_flags←alu_flags.
  - If a new instruction is accepted in the same cycle, go to ISSUE; otherwise go to IDLE.
- In IDLE and WB: alu_X=alu_Y=0, alu_funSel=00.
- Resulting arithmetic, all mod 2^16:
  - ADD: R[rs]+R[rt].
  - SUB: R[rt]−R[rs]; the ALU computes ~X+Y+1.
  - MOV: R[rs].
  - NEG: −R[rs].
- Flags are taken from the ALU unmodified. C and V are always 0 for MOV and NEG.
- Load port: on ld_valid, R[ld_addr]←ld_data at the edge, in any state.
  - If it coincides with a WB write to the same address, the WB write wins and the load is dropped.
- Back-to-back hazard: the operand read happens in ISSUE, which is after the previous WB edge, so dependent instructions see fresh values with no forwarding.
- All registers are ordinary and writable; there is no hard-wired zero.

## Timing
- Reset values (asynchronous):
  - state=IDLE, instr_ready=1, done=0.
  - status_flags=0000.
  - All R[i]=0.
  - alu_X=alu_Y=0, alu_funSel=00.
- Latency:
  - Accept at edge t.
  - ISSUE is cycle t+1; the ALU registers the result at edge t+2.
  - done=1 during cycle t+2.
  - R[rd] and status_flags are visible from cycle t+3.
- Throughput: one instruction per 2 cycles when the next instruction is accepted in WB; 3 cycles via IDLE.
- Reset asserted in ISSUE or WB:
  - The in-flight instruction is discarded: no register-file or flag write.
  - done drops immediately.
- instr_valid with instr_ready=0 (ISSUE): the instruction is not taken; the upstream must hold it.
- The ALU has no reset; alu_Z and alu_flags are sampled only in WB, so their pre-first-op X values never propagate.

## Test plan
- Reset -> instr_ready=1, done=0, status_flags=0000, dbg_rdata=0 for all 8 addresses.
- Load R1=0x0005, R2=0x0003; ADD rd=3 rs=1 rt=2 -> done exactly 2 cycles after accept; R3=0x0008; status_flags=0000.
- SUB rd=4 rs=1 rt=2 (3−5) -> R4=0xFFFE, status_flags=1000 (S=1, V=0, C=0).
- Overflow: R5=0x7FFF, R6=0x0001, ADD rd=7 rs=5 rt=6 -> R7=0x8000, status_flags=1100.
- NEG of R0=0x0000 -> result 0x0000, status_flags=0001 (C masked); MOV of R1 -> 0x0005, flags 0000.
- Back-to-back: ADD rd=3, then in its WB cycle accept ADD rd=4 rs=3 rt=3 -> R4=0x0010.
- Reset pulsed during ISSUE -> no write; done stays 0.
- Load and WB to the same register in the same cycle -> the WB value is kept.
